signed_divider: RTL and testbench
=================================

SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand, quotient and remainder width in bits (legal range 4..32).
REQ-002 SHALL have one clock and a synchronous, active-high reset: aclk  in  1  clock, all logic on its rising edge; areset  in  1  synchronous active-high reset.
REQ-003 SHALL have s_axis_dividend_tdata  in  DATA_W  signed two's-complement dividend.
REQ-004 SHALL have s_axis_dividend_tvalid  in  1  dividend valid.
REQ-005 SHALL have s_axis_divisor_tdata  in  DATA_W  signed two's-complement divisor.
REQ-006 SHALL have s_axis_divisor_tvalid  in  1  divisor valid.
REQ-007 SHALL have s_axis_tready  out  1  shared input ready for both operand channels.
REQ-008 SHALL have m_axis_dout_tdata  out  2*DATA_W  {quotient[2*DATA_W-1:DATA_W], remainder[DATA_W-1:0]}.
REQ-009 SHALL have m_axis_dout_tuser  out  2  bit0 divide-by-zero, bit1 overflow.
REQ-010 SHALL have m_axis_dout_tvalid  out  1  result valid.
REQ-011 SHALL have m_axis_dout_tready  in  1  downstream ready.

Function
REQ-012 SHALL implement a self-contained iterative restoring divider on operand magnitudes with no vendor IP, producing one quotient bit per cycle.
REQ-013 SHALL use FSM states IDLE, LOAD, DIV, FIX, DONE.
REQ-014 SHALL assert s_axis_tready only in IDLE, and SHALL accept operands on an edge where s_axis_tready, s_axis_dividend_tvalid and s_axis_divisor_tvalid are all 1; it SHALL then move IDLE->LOAD.
REQ-015 SHALL ignore a single valid channel without the other and SHALL not accept on it.
REQ-016 SHALL in LOAD register magnitudes and signs, detect a zero divisor and the MIN/-1 case, then move to DIV.
REQ-017 SHALL stay in DIV exactly DATA_W cycles, counted by a bit counter, then move to FIX.
REQ-018 SHALL in FIX apply signs (quotient negated when operand signs differ, remainder takes the dividend sign), then move to DONE.
REQ-019 SHALL assert m_axis_dout_tvalid in DONE, exactly DATA_W+2 cycles after the accept edge, with the same latency for every operand value, including special cases.
REQ-020 SHALL hold tdata and tuser stable while tvalid=1 and tready=0, and SHALL move DONE->IDLE on the tvalid&tready edge; the earliest next accept is the cycle after that edge.
REQ-021 SHALL truncate the quotient toward zero, satisfying dividend = q*divisor + r with |r| < |divisor|.
REQ-022 SHALL handle divide by zero as follows: tuser[0]=1, remainder=dividend, quotient per REQ-027.
REQ-023 SHALL handle dividend=MIN and divisor=-1 as follows: quotient=MIN (wrap), remainder=0, tuser[1]=1.
REQ-024 SHALL otherwise drive tuser=2'b00; a 0 dividend SHALL give q=0, r=0.

Reset
REQ-025 SHALL, while areset=1, force state IDLE, s_axis_tready=0, m_axis_dout_tvalid=0, m_axis_dout_tdata=0, m_axis_dout_tuser=0 and the counter to 0.
REQ-026 SHALL on reset asserted mid-operation (any state) abort without emitting a result, and SHALL assert s_axis_tready=1 in the first cycle after areset falls.

Configuration
REQ-027 SHALL provide macro DIVIDER_ZERO_SAT_EN: when defined, divide-by-zero quotient saturates to 2^(DATA_W-1)-1 for dividend>=0 and to -2^(DATA_W-1) for dividend<0; when undefined, the divide-by-zero quotient is all ones (-1). tuser[0] and the remainder are unaffected.

Verification (DATA_W=16)
REQ-028 SHALL cover 100/7 -> q=0x000E, r=0x0002, tuser=00, tvalid on the 18th edge after accept.
REQ-029 SHALL cover -100/7 -> q=0xFFF2, r=0xFFFE; and 100/-7 -> q=0xFFF2, r=0x0002.
REQ-030 SHALL cover 0x8000/0xFFFF -> q=0x8000, r=0x0000, tuser=10.
REQ-031 SHALL cover 5/0 -> r=0x0005, tuser=01, q=0xFFFF (macro undefined) or q=0x7FFF (macro defined); -5/0 with macro -> q=0x8000.
REQ-032 SHALL cover m_axis_dout_tready=0 for 10 cycles after tvalid -> output held stable, s_axis_tready=0 throughout, accept allowed the cycle after the handshake.
REQ-033 SHALL cover areset pulse during DIV -> no tvalid, all outputs 0, s_axis_tready=1 the cycle after release, and the next division correct.

Source files
------------

// File: rtl/signed_divider_if.sv
// Operand and result stream bundle for signed_divider.
// The slave modport is the divider side; the master modport is the producer/consumer side.
interface signed_divider_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0]   s_axis_dividend_tdata;
  logic                s_axis_dividend_tvalid;
  logic [DATA_W-1:0]   s_axis_divisor_tdata;
  logic                s_axis_divisor_tvalid;
  logic                s_axis_tready;
  logic [2*DATA_W-1:0] m_axis_dout_tdata;
  logic [1:0]          m_axis_dout_tuser;
  logic                m_axis_dout_tvalid;
  logic                m_axis_dout_tready;

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output s_axis_tready,
    output m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid,
    input  m_axis_dout_tready
  );

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  s_axis_tready,
    input  m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid,
    output m_axis_dout_tready
  );
endinterface

// File: rtl/signed_divider.sv
// Iterative restoring signed divider, one quotient bit per cycle, fixed DATA_W+2 latency.
// Optional macro DIVIDER_ZERO_SAT_EN: saturating divide-by-zero quotient instead of all ones.
module signed_divider #(
  parameter int DATA_W = 16
) (
  input logic             aclk,
  input logic             areset,
  signed_divider_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_V = ~MIN_V;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   dvd_q, dvs_q, quo_q, rem_q, b_q;
  logic                q_neg_q, r_neg_q, dz_q, ovf_q;
  logic [2*DATA_W-1:0] dout_q;
  logic [1:0]          tuser_q;
  logic                s_ready, m_valid, accept;
  logic [DATA_W:0]     shifted;
  logic                ge;
  logic [DATA_W-1:0]   diff, q_fix, r_fix;

  assign accept = s_ready & bus.s_axis_dividend_tvalid & bus.s_axis_divisor_tvalid;

  // Outputs are gated by reset so they read zero for the whole time reset is high.
  assign bus.s_axis_tready      = s_ready & ~areset;
  assign bus.m_axis_dout_tvalid = m_valid & ~areset;
  assign bus.m_axis_dout_tdata  = areset ? '0 : dout_q;
  assign bus.m_axis_dout_tuser  = areset ? 2'b00 : tuser_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid) state_d = LOAD;
      end
      LOAD: state_d = DIV;
      DIV:  if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        m_valid = 1'b1;
        if (bus.m_axis_dout_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Restoring step: shift in the next dividend bit and subtract when it fits.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    ge      = shifted >= {1'b0, b_q};
    diff    = shifted[DATA_W-1:0] - b_q;
  end

  always_comb begin
    q_fix = q_neg_q ? -quo_q : quo_q;
    r_fix = r_neg_q ? -rem_q : rem_q;
    if (dz_q) begin
`ifdef DIVIDER_ZERO_SAT_EN
      q_fix = r_neg_q ? MIN_V : MAX_V;
`else
      q_fix = '1;
`endif
      r_fix = dvd_q;
    end else if (ovf_q) begin
      q_fix = MIN_V;
      r_fix = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
      tuser_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvd_q <= bus.s_axis_dividend_tdata;
            dvs_q <= bus.s_axis_divisor_tdata;
          end
        end
        LOAD: begin
          quo_q   <= dvd_q[DATA_W-1] ? -dvd_q : dvd_q;
          b_q     <= dvs_q[DATA_W-1] ? -dvs_q : dvs_q;
          rem_q   <= '0;
          cnt_q   <= '0;
          q_neg_q <= dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1];
          r_neg_q <= dvd_q[DATA_W-1];
          dz_q    <= (dvs_q == '0);
          ovf_q   <= (dvd_q == MIN_V) && (dvs_q == '1);
        end
        DIV: begin
          rem_q <= ge ? diff : shifted[DATA_W-1:0];
          quo_q <= {quo_q[DATA_W-2:0], ge};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          dout_q  <= {q_fix, r_fix};
          tuser_q <= {ovf_q, dz_q};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider (DATA_W=16): vectors with hand-computed quotient/remainder,
// latency, backpressure, single-channel valid and mid-division reset.
module tb_signed_divider;
  localparam int DATA_W = 16;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 aclk = ~aclk;

  signed_divider_if #(.DATA_W(DATA_W)) bus ();

  signed_divider #(.DATA_W(DATA_W)) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                         input logic [15:0] exp_q, input logic [15:0] exp_r,
                         input logic [1:0] exp_u, input int hold);
    int n;
    @(negedge aclk);
    check_value({tag, "_s_tready"}, 32'(bus.s_axis_tready), 32'd1);
    bus.s_axis_dividend_tdata  = dvd;
    bus.s_axis_divisor_tdata   = dvs;
    bus.s_axis_dividend_tvalid = 1'b1;
    bus.s_axis_divisor_tvalid  = 1'b1;
    @(posedge aclk);
    #1;
    bus.s_axis_dividend_tvalid = 1'b0;
    bus.s_axis_divisor_tvalid  = 1'b0;
    n = 0;
    while (bus.m_axis_dout_tvalid !== 1'b1 && n < 40) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check_value({tag, "_latency"}, 32'(n), 32'd18);
    check_value({tag, "_q"}, 32'(bus.m_axis_dout_tdata[31:16]), 32'(exp_q));
    check_value({tag, "_r"}, 32'(bus.m_axis_dout_tdata[15:0]), 32'(exp_r));
    check_value({tag, "_tuser"}, 32'(bus.m_axis_dout_tuser), 32'(exp_u));
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk);
      #1;
      check_value({tag, "_hold_data"}, bus.m_axis_dout_tdata, {exp_q, exp_r});
      check_value({tag, "_hold_tuser"}, 32'(bus.m_axis_dout_tuser), 32'(exp_u));
      check_value({tag, "_hold_tvalid"}, 32'(bus.m_axis_dout_tvalid), 32'd1);
      check_value({tag, "_hold_s_tready"}, 32'(bus.s_axis_tready), 32'd0);
    end
    bus.m_axis_dout_tready = 1'b1;
    @(posedge aclk);
    #1;
    bus.m_axis_dout_tready = 1'b0;
    check_value({tag, "_post_tvalid"}, 32'(bus.m_axis_dout_tvalid), 32'd0);
    check_value({tag, "_post_s_tready"}, 32'(bus.s_axis_tready), 32'd1);
    $display("div %s: 0x%04h / 0x%04h -> q=0x%04h r=0x%04h tuser=%b latency=%0d",
             tag, dvd, dvs, exp_q, exp_r, exp_u, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] zq_pos, zq_neg;
    logic        seen;
`ifdef DIVIDER_ZERO_SAT_EN
    zq_pos = 16'h7FFF;
    zq_neg = 16'h8000;
`else
    zq_pos = 16'hFFFF;
    zq_neg = 16'hFFFF;
`endif
    bus.s_axis_dividend_tdata  = '0;
    bus.s_axis_dividend_tvalid = 1'b0;
    bus.s_axis_divisor_tdata   = '0;
    bus.s_axis_divisor_tvalid  = 1'b0;
    bus.m_axis_dout_tready     = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    check_value("rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
    check_value("rst_tvalid", 32'(bus.m_axis_dout_tvalid), 32'd0);
    check_value("rst_tdata", bus.m_axis_dout_tdata, 32'd0);
    check_value("rst_tuser", 32'(bus.m_axis_dout_tuser), 32'd0);
    areset = 1'b0;
    #1;
    check_value("rel_s_tready", 32'(bus.s_axis_tready), 32'd1);

    run_div("p100_7", 16'd100, 16'd7, 16'h000E, 16'h0002, 2'b00, 0);
    run_div("m100_7", 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 2'b00, 0);
    run_div("p100_m7", 16'd100, 16'hFFF9, 16'hFFF2, 16'h0002, 2'b00, 0);
    run_div("m100_m7", 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 2'b00, 0);
    run_div("min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 2'b10, 0);
    run_div("p5_0", 16'd5, 16'd0, zq_pos, 16'h0005, 2'b01, 0);
    run_div("m5_0", 16'hFFFB, 16'd0, zq_neg, 16'hFFFB, 2'b01, 0);
    run_div("zero_5", 16'd0, 16'd5, 16'h0000, 16'h0000, 2'b00, 0);
    run_div("min_1", 16'h8000, 16'd1, 16'h8000, 16'h0000, 2'b00, 0);
    run_div("min_2", 16'h8000, 16'd2, 16'hC000, 16'h0000, 2'b00, 0);
    run_div("max_min", 16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 2'b00, 0);
    run_div("min_min", 16'h8000, 16'h8000, 16'h0001, 16'h0000, 2'b00, 0);
    run_div("min_m7", 16'h8000, 16'hFFF9, 16'h1249, 16'hFFFF, 2'b00, 0);
    run_div("bp_100_7", 16'd100, 16'd7, 16'h000E, 16'h0002, 2'b00, 10);

    // Only one channel valid must not start a division.
    @(negedge aclk);
    bus.s_axis_dividend_tdata  = 16'd9;
    bus.s_axis_dividend_tvalid = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    check_value("dvd_only_s_tready", 32'(bus.s_axis_tready), 32'd1);
    bus.s_axis_dividend_tvalid = 1'b0;
    bus.s_axis_divisor_tdata   = 16'd3;
    bus.s_axis_divisor_tvalid  = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    check_value("dvs_only_s_tready", 32'(bus.s_axis_tready), 32'd1);
    check_value("single_tvalid", 32'(bus.m_axis_dout_tvalid), 32'd0);
    bus.s_axis_divisor_tvalid = 1'b0;
    $display("single-channel valid: no accept");

    // Reset pulse in the middle of a division.
    @(negedge aclk);
    bus.s_axis_dividend_tdata  = 16'd1000;
    bus.s_axis_divisor_tdata   = 16'd3;
    bus.s_axis_dividend_tvalid = 1'b1;
    bus.s_axis_divisor_tvalid  = 1'b1;
    @(posedge aclk);
    #1;
    bus.s_axis_dividend_tvalid = 1'b0;
    bus.s_axis_divisor_tvalid  = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    areset = 1'b1;
    #1;
    check_value("midrst_s_tready", 32'(bus.s_axis_tready), 32'd0);
    check_value("midrst_tvalid", 32'(bus.m_axis_dout_tvalid), 32'd0);
    check_value("midrst_tdata", bus.m_axis_dout_tdata, 32'd0);
    check_value("midrst_tuser", 32'(bus.m_axis_dout_tuser), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
    check_value("midrst_rel_s_tready", 32'(bus.s_axis_tready), 32'd1);
    check_value("midrst_rel_tdata", bus.m_axis_dout_tdata, 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge aclk);
      #1;
      if (bus.m_axis_dout_tvalid !== 1'b0) seen = 1'b1;
    end
    check_value("midrst_no_tvalid", 32'(seen), 32'd0);
    $display("mid-division reset: result aborted");
    run_div("after_rst", 16'd1000, 16'd3, 16'h014D, 16'h0001, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
